program_counter_ctrl: RTL and testbench
=======================================

// Module: program_counter_ctrl
// PURPOSE
//   Parametrised program counter for the sequencer datapath: sequential stepping with
//   wrap at a programmable limit, stall, absolute jump, call/return through an internal
//   return-address stack (RAS), and sticky stack-error flags.
//   Drives the instruction-memory address; the decode stage supplies the control inputs.
// PARAMETERS
//   WIDTH      32  PC and address width (bits)
//   RESET_VEC  0   PC value after reset and after a wrap
//   STEP       1   sequential increment per enabled cycle
//   RAS_DEPTH  4   return-address stack entries (>=1)
// PORTS
//   clock        in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   enable       in   1          1 = advance this cycle; 0 = stall (all state holds)
//   pc_max       in   WIDTH      last sequential address before wrap
//   jump_valid   in   1          load jump_target
//   call_valid   in   1          push return address, load jump_target
//   ret_valid    in   1          pop RAS into PC
//   jump_target  in   WIDTH      target for jump/call
//   pc           out  WIDTH      current program counter (registered)
//   wrapped      out  1          1-cycle pulse: the previous update was a wrap
//   ras_empty    out  1          RAS holds no entries
//   ras_full     out  1          RAS holds RAS_DEPTH entries
//   ras_ovf      out  1          sticky: call issued while RAS full
//   ras_unf      out  1          sticky: ret issued while RAS empty
// BEHAVIOUR
//   - reset=1 (async): pc=RESET_VEC, RAS count=0, wrapped=0, ras_ovf=0, ras_unf=0;
//     ras_empty=1, ras_full=0. Reset mid-operation discards RAS contents.
//   - All updates on rising clock edge; results visible on pc after that edge (latency 1).
//   - enable=0: pc, RAS, flags hold; wrapped forced 0; control inputs ignored.
//   - enable=1, priority ret > call > jump > sequential (lower ones ignored that cycle):
//     RET : RAS non-empty -> pc=top entry, count-1. Empty -> ras_unf=1, sequential step.
//     CALL: pc=jump_target; RAS not full -> push (pc+STEP) mod 2^WIDTH, count+1.
//           Full -> no push, contents unchanged, ras_ovf=1; jump still taken.
//     JUMP: pc=jump_target; RAS untouched.
//     SEQ : pc>=pc_max (unsigned) -> pc=RESET_VEC, wrapped=1 next cycle;
//           else pc=(pc+STEP) mod 2^WIDTH (no wrap pulse on natural overflow).
//   - wrapped is 1 only in the cycle following a SEQ wrap; 0 after any other update.
//   - RAS is LIFO; count in 0..RAS_DEPTH; ras_empty=(count==0), ras_full=(count==RAS_DEPTH),
//     both combinational from registered count.
//   - pc_max sampled each enabled edge; changing it below current pc forces wrap on
//     next SEQ step.
//   - ras_ovf/ras_unf clear only on reset.
// TESTING
//   1. reset pulse, enable=1, pc_max=3, STEP=1 -> pc 0,1,2,3,0,1; wrapped=1 only in the
//      cycle pc returns to 0.
//   2. pc=2, enable=0 for 5 cycles with jump_valid=1 -> pc stays 2, no RAS change;
//      enable=1 -> jump taken.
//   3. pc=5, call_valid target 0x40 -> pc=0x40, RAS top=6; later ret_valid -> pc=6,
//      ras_empty=1.
//   4. RAS_DEPTH=4: five nested calls -> ras_full after 4th, 5th sets ras_ovf=1 yet
//      jumps; 4 rets return addresses in reverse order; 5th ret sets ras_unf=1, pc steps
//      sequentially.
//   5. ret_valid, call_valid, jump_valid together with non-empty RAS -> pop only,
//      count-1, no push.
//   6. assert reset mid-sequence with 2 RAS entries and ras_ovf=1 -> pc=RESET_VEC
//      immediately (no clock edge), ras_empty=1, flags 0.

Source files
------------

// File: rtl/program_counter_ctrl.sv
// rtl/program_counter_ctrl.sv - program counter with wrap, stall, jump and call/return stack
module program_counter_ctrl #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter logic [WIDTH-1:0]  STEP      = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] pc_max_i,
    input  logic             jump_valid_i,
    input  logic             call_valid_i,
    input  logic             ret_valid_i,
    input  logic [WIDTH-1:0] jump_target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             wrapped_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_ovf_o,
    output logic             ras_unf_o
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    // The stack is kept as a shift register with entry 0 as the top, so push and
    // pop never need a pointer and any depth (including 1) works the same way.
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrapped_q, wrapped_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty;
    logic             full;
    logic [WIDTH-1:0] pc_inc;
    logic             do_seq;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(RAS_DEPTH));
    assign pc_inc = pc_q + STEP;

    // Next-state selection: ret > call > jump > sequential, everything holds when stalled.
    always_comb begin
        pc_d      = pc_q;
        wrapped_d = 1'b0;
        count_d   = count_q;
        ras_d     = ras_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        do_seq    = 1'b0;
        if (enable_i) begin
            if (ret_valid_i) begin
                if (!empty) begin
                    pc_d = ras_q[0];
                    for (int i = 0; i < int'(RAS_DEPTH) - 1; i++) begin
                        ras_d[i] = ras_q[i+1];
                    end
                    count_d = count_q - 1'b1;
                end else begin
                    // A return with nothing to return to degrades to a plain step.
                    unf_d  = 1'b1;
                    do_seq = 1'b1;
                end
            end else if (call_valid_i) begin
                pc_d = jump_target_i;
                if (!full) begin
                    ras_d[0] = pc_inc;
                    for (int i = 1; i < int'(RAS_DEPTH); i++) begin
                        ras_d[i] = ras_q[i-1];
                    end
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (jump_valid_i) begin
                pc_d = jump_target_i;
            end else begin
                do_seq = 1'b1;
            end

            if (do_seq) begin
                if (pc_q >= pc_max_i) begin
                    pc_d      = RESET_VEC;
                    wrapped_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    // State registers; reset discards the stack contents and the sticky error flags.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q      <= RESET_VEC;
            wrapped_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ras_q     <= ras_d;
        end
    end

    assign pc_o        = pc_q;
    assign wrapped_o   = wrapped_q;
    assign ras_empty_o = empty;
    assign ras_full_o  = full;
    assign ras_ovf_o   = ovf_q;
    assign ras_unf_o   = unf_q;

endmodule

// File: tb/tb_program_counter_ctrl.sv
// tb/tb_program_counter_ctrl.sv - scoreboard bench for program_counter_ctrl
module tb_program_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] pc_max;
    logic        jump_valid;
    logic        call_valid;
    logic        ret_valid;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        wrapped;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        wr;
        logic        emp;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb_q [$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_ovf;
    logic        m_unf;

    program_counter_ctrl #(
        .WIDTH    (32),
        .RESET_VEC(32'h0),
        .STEP     (32'h1),
        .RAS_DEPTH(4)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .enable_i     (enable),
        .pc_max_i     (pc_max),
        .jump_valid_i (jump_valid),
        .call_valid_i (call_valid),
        .ret_valid_i  (ret_valid),
        .jump_target_i(jump_target),
        .pc_o         (pc),
        .wrapped_o    (wrapped),
        .ras_empty_o  (ras_empty),
        .ras_full_o   (ras_full),
        .ras_ovf_o    (ras_ovf),
        .ras_unf_o    (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input logic en, input logic jv, input logic cv, input logic rv,
                        input logic [31:0] tgt, input logic [31:0] pmax);
        exp_t        e;
        exp_t        got;
        logic        wr;
        logic        seq;
        logic [31:0] ret_addr;
        enable      = en;
        jump_valid  = jv;
        call_valid  = cv;
        ret_valid   = rv;
        jump_target = tgt;
        pc_max      = pmax;

        wr       = 1'b0;
        seq      = 1'b0;
        ret_addr = m_pc + 32'h1;
        if (en) begin
            if (rv) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_front();
                else begin
                    m_unf = 1'b1;
                    seq   = 1'b1;
                end
            end else if (cv) begin
                m_pc = tgt;
                if (m_ras.size() < 4) m_ras.push_front(ret_addr);
                else m_ovf = 1'b1;
            end else if (jv) begin
                m_pc = tgt;
            end else begin
                seq = 1'b1;
            end
            if (seq) begin
                if (ret_addr - 32'h1 >= pmax) begin
                    m_pc = 32'h0;
                    wr   = 1'b1;
                end else begin
                    m_pc = ret_addr;
                end
            end
        end
        e.pc   = m_pc;
        e.wr   = wr;
        e.emp  = (m_ras.size() == 0);
        e.full = (m_ras.size() == 4);
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("pc", pc, got.pc);
        check("wrapped", {31'b0, wrapped}, {31'b0, got.wr});
        check("ras_empty", {31'b0, ras_empty}, {31'b0, got.emp});
        check("ras_full", {31'b0, ras_full}, {31'b0, got.full});
        check("ras_ovf", {31'b0, ras_ovf}, {31'b0, got.ovf});
        check("ras_unf", {31'b0, ras_unf}, {31'b0, got.unf});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        pc_max      = 32'd3;
        jump_valid  = 1'b0;
        call_valid  = 1'b0;
        ret_valid   = 1'b0;
        jump_target = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_wrapped", {31'b0, wrapped}, 32'h0);
        check("rst_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_full", {31'b0, ras_full}, 32'h0);
        check("rst_ovf", {31'b0, ras_ovf}, 32'h0);
        check("rst_unf", {31'b0, ras_unf}, 32'h0);
        rst = 1'b0;

        // Sequential stepping with wrap at pc_max=3
        repeat (6) step(1, 0, 0, 0, 32'h0, 32'd3);
        check("seq_end_pc", pc, 32'd2);

        // Stall with a pending jump, then let it through
        repeat (5) step(0, 1, 0, 0, 32'h80, 32'd3);
        check("stall_pc", pc, 32'd2);
        step(1, 1, 0, 0, 32'h80, 32'hFFFF);
        check("jump_pc", pc, 32'h80);

        // Call from pc=5, run a bit, return to 6
        step(1, 1, 0, 0, 32'h5, 32'hFFFF);
        step(1, 0, 1, 0, 32'h40, 32'hFFFF);
        check("call_pc", pc, 32'h40);
        repeat (3) step(1, 0, 0, 0, 32'h0, 32'hFFFF);
        step(1, 0, 0, 1, 32'h0, 32'hFFFF);
        check("ret_pc", pc, 32'h6);
        check("ret_empty", {31'b0, ras_empty}, 32'h1);

        // Five nested calls: fourth fills, fifth overflows but still jumps
        for (int i = 1; i <= 5; i++) step(1, 0, 1, 0, 32'(i) << 8, 32'hFFFF);
        check("ovf_jump_pc", pc, 32'h500);
        check("ovf_flag", {31'b0, ras_ovf}, 32'h1);
        // Four returns in reverse order, then an underflowing return steps
        step(1, 0, 0, 1, 32'h0, 32'hFFFF);
        check("ret1", pc, 32'h301);
        step(1, 0, 0, 1, 32'h0, 32'hFFFF);
        check("ret2", pc, 32'h201);
        step(1, 0, 0, 1, 32'h0, 32'hFFFF);
        check("ret3", pc, 32'h101);
        step(1, 0, 0, 1, 32'h0, 32'hFFFF);
        check("ret4", pc, 32'h7);
        step(1, 0, 0, 1, 32'h0, 32'hFFFF);
        check("unf_seq_pc", pc, 32'h8);
        check("unf_flag", {31'b0, ras_unf}, 32'h1);

        // ret+call+jump together with entries on the stack: pop only
        step(1, 0, 1, 0, 32'h20, 32'hFFFF);
        step(1, 0, 1, 0, 32'h30, 32'hFFFF);
        step(1, 1, 1, 1, 32'h99, 32'hFFFF);
        check("combo_pc", pc, 32'h21);
        check("combo_empty", {31'b0, ras_empty}, 32'h0);

        // Lowering pc_max below pc forces a wrap on the next step
        step(1, 0, 0, 0, 32'h0, 32'h4);
        check("lowmax_pc", pc, 32'h0);
        check("lowmax_wrapped", {31'b0, wrapped}, 32'h1);
        step(1, 0, 0, 0, 32'h0, 32'h4);
        check("wrap_pulse_clear", {31'b0, wrapped}, 32'h0);

        // Asynchronous reset with two entries and ovf set, no clock edge needed
        step(1, 0, 1, 0, 32'h60, 32'hFFFF);
        check("pre_rst_ovf", {31'b0, ras_ovf}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_empty", {31'b0, ras_empty}, 32'h1);
        check("arst_ovf", {31'b0, ras_ovf}, 32'h0);
        check("arst_unf", {31'b0, ras_unf}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 32'($urandom_range(0, 40)), 32'($urandom_range(0, 30)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
